// File: rtl/alu_operand_stage.sv
// Decode-to-execute register feeding the ALU: resolves EX/MEM and MEM/WB forwarding,
// selects operand sources and holds the operation under a valid/ready handshake.
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [RIDX-1:0] in_rs1_idx,
    input  logic [RIDX-1:0] in_rs2_idx,
    input  logic [RIDX-1:0] in_rd_idx,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [1:0]      in_srca,
    input  logic [1:0]      in_srcb,
    input  logic [3:0]      in_aluctr,
    input  logic            ex_wen,
    input  logic [RIDX-1:0] ex_idx,
    input  logic [XLEN-1:0] ex_data,
    input  logic            ex_is_load,
    input  logic            wb_wen,
    input  logic [RIDX-1:0] wb_idx,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] dataa,
    output logic [XLEN-1:0] datab,
    output logic [3:0]      aluctr,
    output logic [RIDX-1:0] out_rd,
    output logic [XLEN-1:0] out_rs2_val
);

    // Handshake: an operation moves into this stage when in_valid & in_ready at a rising
    // edge; the held operation leaves when out_valid & out_ready. Once out_valid is high
    // the outputs stay stable until consumed or flushed.
    logic            hazard;
    logic            xfer;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;

    // A load in EX has no data yet, so any consumer of its destination must wait a cycle.
    // rs2 is checked regardless of in_srcb so store data is covered too.
    always_comb begin
        hazard = in_valid & ex_wen & ex_is_load & (ex_idx != '0) &
                 (((in_srca == 2'b00) & (in_rs1_idx == ex_idx)) | (in_rs2_idx == ex_idx));
        in_ready = (~out_valid | out_ready) & ~hazard;
        xfer     = in_valid & in_ready;
    end

    always_comb begin
        rs1_fwd = in_rs1_data;
        if (in_rs1_idx == '0)
            rs1_fwd = '0;
        else if (ex_wen & (ex_idx == in_rs1_idx) & ~ex_is_load)
            rs1_fwd = ex_data;
        else if (wb_wen & (wb_idx == in_rs1_idx))
            rs1_fwd = wb_data;
    end

    always_comb begin
        rs2_fwd = in_rs2_data;
        if (in_rs2_idx == '0)
            rs2_fwd = '0;
        else if (ex_wen & (ex_idx == in_rs2_idx) & ~ex_is_load)
            rs2_fwd = ex_data;
        else if (wb_wen & (wb_idx == in_rs2_idx))
            rs2_fwd = wb_data;
    end

    always_comb begin
        case (in_srca)
            2'b00:   opa = rs1_fwd;
            2'b01:   opa = in_pc;
            default: opa = '0;
        endcase
        case (in_srcb)
            2'b00:   opb = rs2_fwd;
            2'b01:   opb = in_imm;
            2'b10:   opb = XLEN'(4);
            default: opb = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            dataa       <= '0;
            datab       <= '0;
            out_rs2_val <= '0;
            aluctr      <= 4'b1111;
            out_rd      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_valid   <= 1'b1;
            dataa       <= opa;
            datab       <= opb;
            out_rs2_val <= rs2_fwd;
            aluctr      <= in_aluctr;
            out_rd      <= in_rd_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios then random traffic, checked by a
// scoreboard queue filled from a behavioural model and drained by a negedge monitor.
module tb_alu_operand_stage;

    localparam int XLEN = 32;
    localparam int RIDX = 5;
    localparam int EW   = RIDX + 4 + 3 * XLEN;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0, in_pc = '0;
    logic [RIDX-1:0] in_rs1_idx = '0, in_rs2_idx = '0, in_rd_idx = '0;
    logic [1:0]      in_srca = '0, in_srcb = '0;
    logic [3:0]      in_aluctr = '0;
    logic            ex_wen = 1'b0, ex_is_load = 1'b0, wb_wen = 1'b0;
    logic [RIDX-1:0] ex_idx = '0, wb_idx = '0;
    logic [XLEN-1:0] ex_data = '0, wb_data = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] dataa, datab, out_rs2_val;
    logic [3:0]      aluctr;
    logic [RIDX-1:0] out_rd;

    alu_operand_stage #(.XLEN(XLEN), .RIDX(RIDX)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
        .in_imm(in_imm), .in_pc(in_pc), .in_srca(in_srca), .in_srcb(in_srcb),
        .in_aluctr(in_aluctr), .ex_wen(ex_wen), .ex_idx(ex_idx), .ex_data(ex_data),
        .ex_is_load(ex_is_load), .wb_wen(wb_wen), .wb_idx(wb_idx), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .dataa(dataa), .datab(datab), .aluctr(aluctr), .out_rd(out_rd),
        .out_rs2_val(out_rs2_val)
    );

    // ---------------- clock / reset sampling ----------------
    always #5 clk = ~clk;

    logic rst_q = 1'b0;
    always @(posedge clk) rst_q <= rst;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]   exp_q[$];
    logic            exp_ready = 1'b0;
    logic            started = 1'b0;
    logic            spot_en = 1'b0;
    logic [XLEN-1:0] spot_a = '0, spot_b = '0;
    int              checks = 0;
    int              failures = 0;

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] model_src(input logic [RIDX-1:0] idx,
                                                  input logic [XLEN-1:0] rf);
        if (idx == 0) return 0;
        if (ex_wen && ex_idx == idx && !ex_is_load) return ex_data;
        if (wb_wen && wb_idx == idx) return wb_data;
        return rf;
    endfunction

    function automatic logic model_stall();
        if (!(in_valid && ex_wen && ex_is_load && ex_idx != 0)) return 1'b0;
        return (in_srca == 2'b00 && in_rs1_idx == ex_idx) || (in_rs2_idx == ex_idx);
    endfunction

    function automatic logic [EW-1:0] model_entry();
        logic [XLEN-1:0] a, b, s2;
        s2 = model_src(in_rs2_idx, in_rs2_data);
        a = (in_srca == 2'b00) ? model_src(in_rs1_idx, in_rs1_data) :
            (in_srca == 2'b01) ? in_pc : 0;
        b = (in_srcb == 2'b00) ? s2 : (in_srcb == 2'b01) ? in_imm :
            (in_srcb == 2'b10) ? 32'd4 : 0;
        return {in_rd_idx, in_aluctr, s2, b, a};
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic cycle();
        logic            xfer;
        logic [EW-1:0]   ent;
        #1;
        started   = 1'b1;
        exp_ready = ((exp_q.size() == 0) || out_ready) && !model_stall();
        xfer      = in_valid && exp_ready;
        ent       = model_entry();
        @(posedge clk);
        if (rst || flush) exp_q.delete();
        else if (xfer) exp_q.push_back(ent);
        spot_en = 1'b0;
        #1;
    endtask

    task automatic expect_ab(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        spot_a  = a;
        spot_b  = b;
        spot_en = 1'b1;
    endtask

    task automatic set_op(input logic [RIDX-1:0] r1, input logic [XLEN-1:0] d1,
                          input logic [RIDX-1:0] r2, input logic [XLEN-1:0] d2,
                          input logic [1:0] sa, input logic [1:0] sb,
                          input logic [3:0] ctl);
        in_valid = 1'b1; in_rs1_idx = r1; in_rs1_data = d1;
        in_rs2_idx = r2; in_rs2_data = d2; in_srca = sa; in_srcb = sb;
        in_aluctr = ctl; in_rd_idx = RIDX'($urandom_range(1, 31));
    endtask

    // ---------------- monitor ----------------
    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (started) check("in_ready", 32'(in_ready), 32'(exp_ready));
        if (rst_q) begin
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_aluctr", 32'(aluctr), 32'hF);
            check("rst_dataa", dataa, 0);
            check("rst_datab", datab, 0);
            check("rst_rs2_val", out_rs2_val, 0);
            check("rst_out_rd", 32'(out_rd), 0);
        end else if (started) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                e = exp_q[0];
                check("dataa", dataa, e[XLEN-1:0]);
                check("datab", datab, e[2*XLEN-1:XLEN]);
                check("rs2_val", out_rs2_val, e[3*XLEN-1:2*XLEN]);
                check("aluctr", 32'(aluctr), 32'(e[3*XLEN+3:3*XLEN]));
                check("out_rd", 32'(out_rd), 32'(e[EW-1:3*XLEN+4]));
                if (out_ready) void'(exp_q.pop_front());
            end
            if (spot_en) begin
                check("spot_dataa", dataa, spot_a);
                check("spot_datab", datab, spot_b);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b1;
        cycle(); cycle();
        rst = 1'b0;

        // pass-through
        set_op(5, 32'h10, 6, 32'h20, 2'b00, 2'b00, 4'b0000);
        cycle(); expect_ab(32'h10, 32'h20);

        // forwarding priority: EX over WB, WB over regfile, x0 always zero
        set_op(7, 32'h1234, 6, 32'h20, 2'b00, 2'b00, 4'b0010);
        ex_wen = 1; ex_idx = 7; ex_data = 32'hAAAA;
        wb_wen = 1; wb_idx = 7; wb_data = 32'hBBBB;
        cycle(); expect_ab(32'hAAAA, 32'h20);
        ex_wen = 0;
        cycle(); expect_ab(32'hBBBB, 32'h20);
        set_op(0, 32'h1234, 6, 32'h20, 2'b00, 2'b00, 4'b0011);
        ex_wen = 1; ex_idx = 0;
        cycle(); expect_ab(32'h0, 32'h20);

        // load-use interlock, then WB forward once the load has moved on
        set_op(3, 32'h9999, 6, 32'h20, 2'b00, 2'b00, 4'b0100);
        ex_wen = 1; ex_is_load = 1; ex_idx = 3; wb_wen = 0;
        cycle();
        ex_wen = 0; ex_is_load = 0; wb_wen = 1; wb_idx = 3; wb_data = 32'h55;
        cycle(); expect_ab(32'h55, 32'h20);
        wb_wen = 0;

        // backpressure for 4 cycles, then accept with no bubble
        out_ready = 0;
        set_op(9, 32'h900, 10, 32'hA00, 2'b00, 2'b00, 4'b0101);
        repeat (4) cycle();
        out_ready = 1;
        cycle(); expect_ab(32'h900, 32'hA00);

        // source selection
        set_op(9, 32'h900, 10, 32'hA00, 2'b01, 2'b10, 4'b0110);
        in_pc = 32'h100;
        cycle(); expect_ab(32'h100, 32'h4);
        set_op(9, 32'h900, 10, 32'hA00, 2'b00, 2'b01, 4'b0111);
        in_imm = 32'hFFFF_FFF0;
        cycle(); expect_ab(32'h900, 32'hFFFF_FFF0);

        // flush while valid with an input transferring: both are lost
        set_op(11, 32'hB00, 12, 32'hC00, 2'b00, 2'b00, 4'b1000);
        flush = 1;
        cycle();
        flush = 0; in_valid = 0;
        cycle();

        // reset in the middle of a stall
        set_op(13, 32'hD00, 14, 32'hE00, 2'b00, 2'b00, 4'b1001);
        cycle();
        out_ready = 0;
        cycle();
        rst = 1;
        cycle();
        rst = 0;

        // random traffic
        for (int n = 0; n < 600; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_rs1_idx  = RIDX'($urandom_range(0, 7));
            in_rs2_idx  = RIDX'($urandom_range(0, 7));
            in_rd_idx   = RIDX'($urandom_range(0, 31));
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            in_imm      = $urandom;
            in_pc       = $urandom;
            in_srca     = 2'($urandom_range(0, 3));
            in_srcb     = 2'($urandom_range(0, 3));
            in_aluctr   = 4'($urandom_range(0, 15));
            ex_wen      = $urandom_range(0, 1) == 1;
            ex_is_load  = $urandom_range(0, 2) == 0;
            ex_idx      = RIDX'($urandom_range(0, 7));
            ex_data     = $urandom;
            wb_wen      = $urandom_range(0, 1) == 1;
            wb_idx      = RIDX'($urandom_range(0, 7));
            wb_data     = $urandom;
            flush       = $urandom_range(0, 19) == 0;
            rst         = $urandom_range(0, 99) == 0;
            out_ready   = $urandom_range(0, 2) != 0;
            cycle();
        end

        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        repeat (3) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
